// File: rtl/fifo_pkg.sv
// fifo_pkg: shared types and constants for the async_fifo read-side stream.
//   occ_e          skid buffer occupancy state (S_EMPTY / S_ONE / S_TWO)
//   FIFO_RD_CNT_W  width of the optional delivered-word counter
//   occ_num()      occupancy state as a 2-bit word count
package fifo_pkg;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } occ_e;

  localparam int FIFO_RD_CNT_W = 32;

  function automatic logic [1:0] occ_num(input occ_e s);
    return logic'(s[1]) ? 2'd2 : (logic'(s[0]) ? 2'd1 : 2'd0);
  endfunction

endpackage

// File: rtl/fifo_rd_stream_if.sv
// fifo_rd_stream_if: FIFO read port plus valid/ready output stream.
//   empty, read_data  FIFO status and data (FIFO -> consumer)
//   rd_en             FIFO read request   (consumer -> FIFO)
//   flush             synchronous discard request
//   out_valid/out_data/out_ready  downstream stream handshake
// Modports: master = the consumer block, slave = its environment.
interface fifo_rd_stream_if #(
  parameter int WIDTH = 8
);
  logic             empty;
  logic [WIDTH-1:0] read_data;
  logic             rd_en;
  logic             flush;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;

  modport master (
    input  empty, read_data, flush, out_ready,
    output rd_en, out_valid, out_data
  );

  modport slave (
    output empty, read_data, flush, out_ready,
    input  rd_en, out_valid, out_data
  );
endinterface

// File: rtl/fifo_rd_stream_skid_buf2.sv
// skid_buf2: 2-entry in-order buffer.
//   clk, reset  clock, asynchronous active-low reset
//   push, din   write din at the tail on this edge
//   pop         drop the head entry on this edge
//   clear       empty the buffer (overrides push)
//   head        oldest entry
//   occ         occupancy state
module skid_buf2
  import fifo_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output occ_e             occ
);

  occ_e             state_q, state_d;
  logic [WIDTH-1:0] ent0_q, ent0_d;
  logic [WIDTH-1:0] ent1_q, ent1_d;

  always_comb begin
    state_d = state_q;
    ent0_d  = ent0_q;
    ent1_d  = ent1_q;
    case (state_q)
      S_EMPTY: begin
        if (push) begin
          state_d = S_ONE;
          ent0_d  = din;
        end
      end
      S_ONE: begin
        if (push && pop) begin
          ent0_d = din;
        end else if (push) begin
          state_d = S_TWO;
          ent1_d  = din;
        end else if (pop) begin
          state_d = S_EMPTY;
        end
      end
      S_TWO: begin
        // Push without pop is never issued in S_TWO: the read gate upstream
        // stops requesting once buffered plus in-flight words reach two.
        if (pop) begin
          ent0_d = ent1_q;
          if (push) begin
            ent1_d = din;
          end else begin
            state_d = S_ONE;
          end
        end
      end
      default: state_d = S_EMPTY;
    endcase
    if (clear) begin
      state_d = S_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_EMPTY;
      ent0_q  <= '0;
      ent1_q  <= '0;
    end else begin
      state_q <= state_d;
      ent0_q  <= ent0_d;
      ent1_q  <= ent1_d;
    end
  end

  assign head = ent0_q;
  assign occ  = state_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: read-side consumer for async_fifo, rd_clk domain.
// Issues rd_en, captures read_data one cycle after each accepted read, and
// presents the words oldest-first on a valid/ready stream through a 2-entry
// skid buffer.
//   rd_clk     FIFO read clock
//   reset      asynchronous active-low reset
//   bus        fifo_rd_stream_if.master (FIFO port + output stream + flush)
//   out_count  32-bit count of delivered words (only with FIFO_RD_CNT_EN)
// Build option: define FIFO_RD_CNT_EN to add the out_count port and counter.
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                     rd_clk,
  input  logic                     reset,
  fifo_rd_stream_if.master         bus
`ifdef FIFO_RD_CNT_EN
  ,
  output logic [FIFO_RD_CNT_W-1:0] out_count
`endif
);

  occ_e             occ;
  logic [WIDTH-1:0] head;
  logic             inflight_q, inflight_d;
  logic             fire;
  logic [1:0]       fill;
  logic             rd_en_c;

  assign fire = (occ != S_EMPTY) && bus.out_ready;
  assign fill = occ_num(occ) + {1'b0, inflight_q};

  // Read only when the word can land: room for it once in-flight words are
  // counted, or a slot is freed by this cycle's fire. reset gates the output
  // so nothing is requested while the FIFO is being reset alongside.
  always_comb begin
    rd_en_c    = reset && !bus.empty && !bus.flush && ((fill < 2'd2) || fire);
    inflight_d = rd_en_c;
  end

  always_ff @(posedge rd_clk or negedge reset) begin
    if (!reset) begin
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
    end
  end

  skid_buf2 #(
    .WIDTH (WIDTH)
  ) u_skid (
    .clk   (rd_clk),
    .reset (reset),
    .push  (inflight_q),
    .pop   (fire),
    .clear (bus.flush),
    .din   (bus.read_data),
    .head  (head),
    .occ   (occ)
  );

  assign bus.rd_en     = rd_en_c;
  assign bus.out_valid = (occ != S_EMPTY);
  assign bus.out_data  = head;

`ifdef FIFO_RD_CNT_EN
  logic [FIFO_RD_CNT_W-1:0] count_q, count_d;

  // Fires in a flush cycle still count; only reset clears the counter.
  always_comb begin
    count_d = count_q + FIFO_RD_CNT_W'(fire);
  end

  always_ff @(posedge rd_clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign out_count = count_q;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: bench for fifo_rd_stream. The FIFO is a queue, the
// stream buffer is a queue of words, and a word read on one edge joins the
// buffer on the following edge. Each step drives inputs on the falling edge
// and compares the DUT against the model 1 time unit later.
module tb_fifo_rd_stream;
  import fifo_pkg::*;

  localparam int W = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fifo_rd_stream_if #(.WIDTH(W)) bus ();

`ifdef FIFO_RD_CNT_EN
  logic [31:0] out_count;
`endif

  fifo_rd_stream #(
    .WIDTH (W)
  ) dut (
    .rd_clk (clk),
    .reset  (reset),
    .bus    (bus)
`ifdef FIFO_RD_CNT_EN
    ,
    .out_count (out_count)
`endif
  );

  int checks = 0;
  int errors = 0;

  logic [W-1:0] fifo_q[$];
  logic [W-1:0] buf_m[$];
  logic [W-1:0] delivered[$];
  logic         inflight_m = 1'b0;
  logic [W-1:0] pend_m = '0;
  logic [31:0]  cnt_m = '0;

  int           rd_pulses;
  int           lidx;
  logic         lrd[64];
  logic         lv[64];
  logic [W-1:0] ld[64];
  logic [W-1:0] words[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic start_log();
    lidx      = 0;
    rd_pulses = 0;
    delivered.delete();
  endtask

  // One clock cycle; entered and left on a falling edge.
  task automatic step(input bit rdy, input bit fl, input bit hold_e);
    bit exp_v, exp_rd, fire, rd;
    if (inflight_m) bus.read_data = pend_m;
    else            bus.read_data = W'($urandom);
    bus.out_ready = rdy;
    bus.flush     = fl;
    bus.empty     = hold_e || (fifo_q.size() == 0);
    #1;
    exp_v = (buf_m.size() != 0);
    chk("out_valid", 32'(bus.out_valid), 32'(exp_v));
    if (exp_v) chk("out_data", 32'(bus.out_data), 32'(buf_m[0]));
    fire   = exp_v && rdy;
    exp_rd = !bus.empty && !fl && ((buf_m.size() + int'(inflight_m)) < 2 || fire);
    chk("rd_en", 32'(bus.rd_en), 32'(exp_rd));
    chk("no_overfill",
        32'((dut.occ == S_TWO) && dut.inflight_q && !(bus.out_valid && rdy)), 32'(0));
`ifdef FIFO_RD_CNT_EN
    chk("out_count", out_count, cnt_m);
`endif
    if (lidx < 64) begin
      lrd[lidx] = bus.rd_en;
      lv[lidx]  = bus.out_valid;
      ld[lidx]  = bus.out_data;
    end
    lidx++;
    if (bus.rd_en) rd_pulses++;
    // Effect of the coming rising edge.
    if (fire) begin
      delivered.push_back(buf_m.pop_front());
      cnt_m++;
    end
    if (inflight_m) buf_m.push_back(pend_m);
    if (fl) buf_m.delete();
    rd = bus.rd_en && !bus.empty;
    inflight_m = rd;
    if (rd) pend_m = fifo_q.pop_front();
    @(negedge clk);
  endtask

  initial begin
    reset         = 1'b0;
    bus.empty     = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    bus.read_data = '0;

    // Reset: rd_en held low even with empty low.
    repeat (3) @(negedge clk);
    #1;
    chk("reset_rd_en", 32'(bus.rd_en), 32'(0));
    chk("reset_out_valid", 32'(bus.out_valid), 32'(0));
    chk("reset_out_data", 32'(bus.out_data), 32'(0));
    @(negedge clk);
    reset = 1'b1;

    // Idle with the FIFO empty.
    start_log();
    repeat (10) step(1, 0, 0);
    chk("idle_rd_pulses", 32'(rd_pulses), 32'(0));
`ifdef FIFO_RD_CNT_EN
    chk("idle_count", out_count, 32'(0));
`endif

    // Streaming three words into an always-ready sink. A word read in cycle
    // n is on read_data in n+1 and becomes the head in n+2.
    fifo_q = '{8'hA5, 8'h5A, 8'h3C};
    start_log();
    repeat (7) step(1, 0, 0);
    chk("stream_rd_pulses", 32'(rd_pulses), 32'(3));
    chk("stream_rd_pattern", 32'({lrd[0], lrd[1], lrd[2], lrd[3]}), 32'(4'b1110));
    chk("stream_valid_pattern", 32'({lv[1], lv[2], lv[3], lv[4], lv[5]}), 32'(5'b01110));
    chk("stream_word0", 32'(ld[2]), 32'h A5);
    chk("stream_word1", 32'(ld[3]), 32'h 5A);
    chk("stream_word2", 32'(ld[4]), 32'h 3C);
`ifdef FIFO_RD_CNT_EN
    chk("stream_count", out_count, 32'd3);
`endif

    // Back-pressure: 16 words, sink stalled for 5 cycles.
    for (int i = 0; i < 16; i++) begin
      words[i] = W'($urandom);
      fifo_q.push_back(words[i]);
    end
    start_log();
    repeat (5) step(0, 0, 0);
    chk("stall_rd_pulses", 32'(rd_pulses), 32'(2));
    chk("stall_hold2", 32'(ld[2]), 32'(words[0]));
    chk("stall_hold4", 32'(ld[4]), 32'(words[0]));
    chk("stall_valid", 32'({lv[2], lv[3], lv[4]}), 32'(3'b111));
    repeat (40) step(1, 0, 0);
    chk("bp_delivered", 32'(delivered.size()), 32'(16));
    for (int i = 0; i < 16; i++) begin
      if (i < delivered.size()) chk("bp_order", 32'(delivered[i]), 32'(words[i]));
    end

    // Empty race: the last read is issued with one word buffered.
    fifo_q = '{8'h11, 8'h22, 8'h33};
    start_log();
    repeat (7) step(1, 0, 0);
    chk("race_rd_pattern", 32'({lrd[0], lrd[1], lrd[2], lrd[3], lrd[4], lrd[5], lrd[6]}),
        32'(7'b1110000));
    chk("race_last_word", 32'(ld[4]), 32'h33);
    chk("race_valid_drop", 32'({lv[4], lv[5], lv[6]}), 32'(3'b100));
    chk("race_delivered", 32'(delivered.size()), 32'(3));

    // Flush with one word buffered and one in flight.
    fifo_q = '{8'h41, 8'h42, 8'h43, 8'h44};
    start_log();
    step(0, 0, 0);
    step(0, 0, 0);
    step(0, 1, 0);
    repeat (6) step(1, 0, 0);
    chk("flush_pre_head", 32'(ld[2]), 32'h41);
    chk("flush_valid_next", 32'(lv[3]), 32'(0));
    chk("flush_resume_word", 32'(ld[5]), 32'h43);
    chk("flush_resume_valid", 32'(lv[5]), 32'(1));

    // Flush with two words buffered.
    fifo_q = '{8'h51, 8'h52, 8'h53};
    start_log();
    repeat (3) step(0, 0, 0);
    step(0, 1, 0);
    repeat (5) step(1, 0, 0);
    chk("flush2_full", 32'({lv[3], ld[3]}), 32'({1'b1, 8'h51}));
    chk("flush2_valid_next", 32'(lv[4]), 32'(0));
    chk("flush2_resume_word", 32'(ld[6]), 32'h53);

`ifdef FIFO_RD_CNT_EN
    // Counter wrap.
    force dut.count_q = 32'hFFFF_FFFE;
    #1;
    release dut.count_q;
    cnt_m = 32'hFFFF_FFFE;
    @(negedge clk);
    fifo_q = '{8'h61, 8'h62, 8'h63};
    repeat (8) step(1, 0, 0);
    chk("count_wrap", out_count, 32'd1);
`endif

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 2) != 0) fifo_q.push_back(W'($urandom));
      step(1'($urandom_range(0, 1)), $urandom_range(0, 19) == 0, $urandom_range(0, 5) == 0);
    end

    // Asynchronous reset mid-stream.
    fifo_q = '{8'h71, 8'h72, 8'h73};
    repeat (3) step(0, 0, 0);
    reset = 1'b0;
    #1;
    chk("midreset_valid", 32'(bus.out_valid), 32'(0));
    chk("midreset_rd_en", 32'(bus.rd_en), 32'(0));
    chk("midreset_data", 32'(bus.out_data), 32'(0));
`ifdef FIFO_RD_CNT_EN
    chk("midreset_count", out_count, 32'(0));
`endif
    fifo_q.delete();
    buf_m.delete();
    inflight_m = 1'b0;
    cnt_m      = '0;
    @(negedge clk);
    reset = 1'b1;
    fifo_q = '{8'h81};
    start_log();
    repeat (5) step(1, 0, 0);
    chk("post_reset_word", 32'(ld[2]), 32'h81);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
